// File: rtl/router_out_arbiter_pkg.sv
// Shared router types and constants.
// Holds the arbiter state encoding and the flit layout.
package router_out_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int DEF_WIDTH = 11;
  localparam int TAIL_BIT  = DEF_WIDTH - 1;

  function automatic int tail_idx(input int w);
    return w - 1;
  endfunction

endpackage

// File: rtl/router_out_arbiter_rr_pick.sv
// Round-robin priority pick.
// Returns the first requester at or after ptr, searching upward mod NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  int idx;

  // Walk from the farthest slot back so the nearest request wins.
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Wormhole output arbiter.
// Locks one input until its tail flit transfers, then rotates priority.
module router_out_arbiter
  import router_out_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       in_valid,
  input  logic [NREQ*WIDTH-1:0] in_data,
  output logic [NREQ-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [NREQ-1:0]       grant,
  output logic [7:0]            pkt_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TB = tail_idx(WIDTH);

  arb_state_t      state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   next_ptr;
  logic [NREQ-1:0] pick;
  logic            locked;
  logic            xfer;
  logic            tail;

  rr_pick #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_pick (
    .req(in_valid),
    .ptr(rr_ptr),
    .gnt(pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  assign locked    = (state == LOCKED);
  assign out_valid = locked & in_valid[owner];
  assign out_data  = locked ? in_data[owner*WIDTH +: WIDTH] : '0;
  assign in_ready  = locked ? (grant & {NREQ{out_ready}}) : '0;
  assign xfer      = out_valid & out_ready;
  assign tail      = out_data[TB];
  assign next_ptr  = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      pkt_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|in_valid) begin
            grant <= pick;
            owner <= pick_idx;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          // Only the tail releases the lock; stalls and gaps keep it.
          if (xfer && tail) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= next_ptr;
            pkt_count <= pkt_count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter.
// Expected flits are queued on load and popped when the output transfers.
module tb_router_out_arbiter;

  localparam int N = 4;
  localparam int W = 11;

  typedef struct packed {
    logic [N-1:0] g;
    logic [W-1:0] d;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [N-1:0] grant;
  logic [7:0]   pkt_count;

  logic [W-1:0] q [N][$];
  exp_t         sb [$];
  int           total = 0;
  int           bad   = 0;

  router_out_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .grant    (grant),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i] = (q[i].size() > 0);
      if (q[i].size() > 0) in_data[i*W +: W] = q[i][0];
      else in_data[i*W +: W] = '0;
    end
  endtask

  task automatic load(input int r, input logic [W-1:0] f);
    q[r].push_back(f);
    drive();
  endtask

  task automatic expect_x(input logic [N-1:0] g, input logic [W-1:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) q[i].delete();
    sb.delete();
    drive();
  endtask

  task automatic tick();
    logic [N-1:0] fire;
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_xfer observed=%0h expected=none", out_data);
      end else begin
        e = sb.pop_front();
        chk("xfer_data", 32'(out_data), 32'(e.d));
        chk("xfer_owner", 32'(grant), 32'(e.g));
      end
    end
    fire = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire[i]) void'(q[i].pop_front());
    end
    drive();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    #3;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    do_reset();

    // single flit from requester 0
    load(0, 11'b10000000001);
    expect_x(4'b0001, 11'b10000000001);
    tick();
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_ovalid", 32'(out_valid), 32'd1);
    tick();
    chk("single_release", 32'(grant), 32'd0);
    chk("single_pkt", 32'(pkt_count), 32'd1);

    // rr_ptr now 1: requester 1 wins over 0
    load(0, 11'b10000000010);
    load(1, 11'b10000000011);
    expect_x(4'b0010, 11'b10000000011);
    expect_x(4'b0001, 11'b10000000010);
    tick();
    chk("ptr1_grant", 32'(grant), 32'h2);
    drain(10);

    // four requesters with continuous tail packets
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < N; r++) begin
        load(r, {1'b1, 6'd0, 4'(k*N + r)});
        expect_x(4'(1 << r), {1'b1, 6'd0, 4'(k*N + r)});
      end
    end
    tick();
    chk("rot_first", 32'(grant), 32'h1);
    repeat (7) tick();
    chk("rot_pkt4", 32'(pkt_count), 32'd4);
    drain(20);
    chk("rot_pkt8", 32'(pkt_count), 32'd8);

    // move pointer to 2, then a 3-flit packet on 2 with 0 waiting
    load(1, 11'b10000000111);
    expect_x(4'b0010, 11'b10000000111);
    drain(10);
    load(2, 11'b00000000000);
    load(2, 11'b01111111111);
    load(2, 11'b10101010101);
    load(0, 11'b10000000011);
    expect_x(4'b0100, 11'b00000000000);
    expect_x(4'b0100, 11'b01111111111);
    expect_x(4'b0100, 11'b10101010101);
    expect_x(4'b0001, 11'b10000000011);
    tick();
    chk("worm_grant", 32'(grant), 32'h4);
    tick();
    tick();
    chk("worm_hold", 32'(grant), 32'h4);
    tick();
    chk("worm_release", 32'(grant), 32'd0);
    tick();
    chk("worm_next", 32'(grant), 32'h1);
    drain(10);

    // stall mid-packet on requester 3
    load(3, 11'b00000001111);
    load(3, 11'b10000001111);
    expect_x(4'b1000, 11'b00000001111);
    expect_x(4'b1000, 11'b10000001111);
    tick();
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("stall_ovalid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(11'b10000001111));
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_grant", 32'(grant), 32'h8);
    end
    out_ready = 1'b1;
    drain(10);
    chk("stall_pkt", 32'(pkt_count), 32'd12);

    // reset during the second flit of a packet
    load(2, 11'b00000000001);
    load(2, 11'b00000000010);
    load(2, 11'b10000000011);
    expect_x(4'b0100, 11'b00000000001);
    tick();
    tick();
    chk("mid_ovalid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_ovalid", 32'(out_valid), 32'd0);
    chk("async_ready", 32'(in_ready), 32'd0);
    chk("async_pkt", 32'(pkt_count), 32'd0);
    chk("abandon_sb", 32'(sb.size()), 32'd0);
    clear_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    load(3, 11'b10000000100);
    load(0, 11'b10000000101);
    expect_x(4'b0001, 11'b10000000101);
    expect_x(4'b1000, 11'b10000000100);
    tick();
    chk("rearb_grant", 32'(grant), 32'h1);
    drain(10);
    chk("rearb_pkt", 32'(pkt_count), 32'd2);

    // 257 packets wraps the counter to 1
    do_reset();
    for (int k = 0; k < 257; k++) begin
      load(0, {1'b1, 10'(k)});
      expect_x(4'b0001, {1'b1, 10'(k)});
    end
    drain(600);
    chk("wrap_pkt", 32'(pkt_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
